btb_predictor: RTL and testbench
================================

# btb_predictor

Parametrised branch target buffer with per-entry saturating direction counters, replacing the fixed always-not-taken predictor in the IF stage of the pipelined CPU. Looks up the fetch PC combinationally and returns the predicted next PC in the same cycle. Trained from the EX stage (branches) and ID stage (jumps) when control-flow instructions resolve. Keeps a saturating misprediction count for the `num_inst` penalty accounting.

## Interface
Parameters:
- `WORD_SIZE`, 16: PC and target width.
- `INDEX_BITS`, 4: log2 of the entry count (16 entries by default).
- `CTR_BITS`, 2: width of the direction counter; must be at least 1.

Ports (clock and reset first):
- `Clk`  in  1  clock. All state updates on the rising edge.
- `Reset_N`  in  1  reset, synchronous, active-low.
- `PC`  in  WORD_SIZE  current fetch PC.
- `Prediction`  out  WORD_SIZE  predicted next PC (combinational).
- `pred_hit`  out  1  valid entry with matching tag for `PC`.
- `pred_taken`  out  1  `pred_hit` and counter MSB = 1.
- `upd_valid`  in  1  a resolved branch or jump this cycle.
- `upd_pc`  in  WORD_SIZE  PC of the resolved instruction.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  WORD_SIZE  actual taken target.
- `upd_mispredict`  in  1  the pipeline flushed for this update. Qualified by `upd_valid`.
- `mispredict_count`  out  WORD_SIZE  saturating count of mispredictions.

## Operation
- **Address split.** index = `PC[INDEX_BITS-1:0]`; tag = `PC[WORD_SIZE-1:INDEX_BITS]`.
- **Entry contents.** valid bit, tag, target, counter.
- **Lookup** (purely combinational):
  - hit = valid AND tag match.
  - `Prediction` = target if `pred_taken`, else `PC+1`.
  - `PC+1` is modulo 2^WORD_SIZE, so 16'hFFFF gives 16'h0000.
- **Update** when `upd_valid` = 1, on the rising edge:
  - **Hit at `upd_pc`:** counter +1 if taken, -1 if not taken. It saturates at all-ones and at 0 (no wrap). If taken, the target is overwritten with `upd_target`.
  - **Miss and taken:** allocate the entry (overwrite unconditionally, direct-mapped). Set valid=1, tag, target, and counter = weakly taken (MSB=1, other bits 0).
  - **Miss and not taken:** no change.
- **Misprediction count.** `mispredict_count` increments by 1 when `upd_valid` and `upd_mispredict` are both 1, and holds at all-ones.
- **Simultaneous lookup and update of the same index.** The lookup returns the pre-update contents. There is no write-through bypass.
- **Reset.** `Reset_N` = 0 on a rising edge does all of the following and takes precedence over any `upd_valid` in the same cycle:
  - all valid bits cleared;
  - all counters set to weakly not taken (MSB=0, rest 1);
  - targets and tags set to 0;
  - `mispredict_count` set to 0;
  - history register (if configured) set to 0.

## Timing
- Lookup latency: 0 cycles. The outputs settle from `PC` and the current state within the same cycle.
- Update latency: 1 cycle. A lookup in the cycle after an update edge sees the new state.
- Output values after reset: `pred_hit`=0, `pred_taken`=0, `Prediction`=`PC+1`, `mispredict_count`=0.
- No handshake. The update port is fire-and-forget and accepts one update per cycle.

## Configuration
- Macro: `BTB_GSHARE_EN`.
- **Defined:** adds an INDEX_BITS-wide global history register (GHR).
  - The counter table index becomes `PC[INDEX_BITS-1:0]` XOR GHR for lookup, and `upd_pc[INDEX_BITS-1:0]` XOR GHR for update. The update uses the GHR value before its own shift.
  - The tag, valid and target arrays stay indexed by PC alone.
  - On `upd_valid`, GHR shifts left with `upd_taken` inserted at bit 0.
- **Undefined:** no GHR. Counters are indexed by PC only, exactly as in Operation.

## Structure
- **Shared package/header:** `WORD_SIZE`, the counter encodings `CTR_WEAK_NT` and `CTR_WEAK_T` (expressed as functions of `CTR_BITS`), and an entry struct/typedef of valid, tag, target and counter.
- **Sub-module:** one, `sat_counter` (CTR_BITS-wide saturating up/down update logic), used once per entry or shared through the update path.

## Test plan
- **Reset state:** reset, then `PC`=16'h0010 → `Prediction`=16'h0011, `pred_hit`=0, `mispredict_count`=0.
- **Allocate on taken miss:** `upd_valid`=1, `upd_pc`=16'h0010, `upd_taken`=1, `upd_target`=16'h0040 → next cycle `PC`=16'h0010 gives `pred_hit`=1, `pred_taken`=1, `Prediction`=16'h0040.
- **Counter saturation and hysteresis:** 3 further taken updates at 16'h0010, then 1 not-taken update → still predicts 16'h0040. A second not-taken update → `Prediction`=16'h0011.
- **Tag conflict:** after allocating 16'h0010, a taken update at 16'h0110 (same index) with target 16'h0080 → `PC`=16'h0010 misses and predicts 16'h0011; `PC`=16'h0110 predicts 16'h0080.
- **Same-cycle update and wrap:**
  - A lookup in the same cycle as an allocating update returns the old (miss) result.
  - `PC`=16'hFFFF on a miss predicts 16'h0000.
- **Counter and reset priority:** 5 updates with `upd_mispredict`=1 → `mispredict_count`=5. Reset asserted together with `upd_valid` → count 0 and no entry allocated.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor_pkg
// Description : Shared constants, counter encodings and the default-sized
//               entry type for the branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_predictor_pkg;

    // Default PC / target width of the CPU.
    localparam int WORD_SIZE  = 16;
    localparam int INDEX_BITS = 4;
    localparam int CTR_BITS   = 2;

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic int ctr_weak_nt(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    // Weakly-taken: MSB set, all lower bits clear.
    function automatic int ctr_weak_t(input int bits);
        return 1 << (bits - 1);
    endfunction

    // Entry layout at the default configuration; the predictor builds the
    // same layout from its own parameters.
    typedef struct packed {
        logic                             valid;
        logic [WORD_SIZE-INDEX_BITS-1:0]  tag;
        logic [WORD_SIZE-1:0]             target;
        logic [CTR_BITS-1:0]              ctr;
    } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/btb_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Combinational saturating up/down step of a direction counter.
//               Sticks at all-ones when incrementing and at zero when
//               decrementing.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] i_ctr,
    input  logic                i_inc,
    output logic [CTR_BITS-1:0] o_ctr
);

    // One saturating step in the direction of i_inc.
    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != {CTR_BITS{1'b1}}) o_ctr = i_ctr + CTR_BITS'(1);
        end else begin
            if (i_ctr != {CTR_BITS{1'b0}}) o_ctr = i_ctr - CTR_BITS'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor
// Description : Direct-mapped branch target buffer with per-entry saturating
//               direction counters and a saturating misprediction counter.
//               Lookup is combinational; training happens on the rising edge.
//               Optional macro BTB_GSHARE_EN adds a global history register
//               that is XORed into the counter index.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor #(
    parameter int WORD_SIZE  = btb_predictor_pkg::WORD_SIZE,
    parameter int INDEX_BITS = btb_predictor_pkg::INDEX_BITS,
    parameter int CTR_BITS   = btb_predictor_pkg::CTR_BITS
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic [WORD_SIZE-1:0] PC,
    output logic [WORD_SIZE-1:0] Prediction,
    output logic                 pred_hit,
    output logic                 pred_taken,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispredict,
    output logic [WORD_SIZE-1:0] mispredict_count
);
    import btb_predictor_pkg::*;

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    localparam logic [CTR_BITS-1:0] c_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] c_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [WORD_SIZE-1:0] target;
        logic [CTR_BITS-1:0]  ctr;
    } entry_t;

    localparam entry_t c_RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: c_WEAK_NT};

    entry_t               entry_q [ENTRIES];
    entry_t               entry_d [ENTRIES];
    logic [WORD_SIZE-1:0] mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] w_lk_idx, w_lk_ctr_idx;
    logic [INDEX_BITS-1:0] w_up_idx, w_up_ctr_idx;
    logic [TAG_W-1:0]      w_lk_tag, w_up_tag;
    logic                  w_up_hit;
    logic [CTR_BITS-1:0]   w_ctr_next;

    assign w_lk_idx = PC[INDEX_BITS-1:0];
    assign w_lk_tag = PC[WORD_SIZE-1:INDEX_BITS];
    assign w_up_idx = upd_pc[INDEX_BITS-1:0];
    assign w_up_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];

`ifdef BTB_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;

    // Counters are indexed by PC hashed with the pre-shift history.
    assign w_lk_ctr_idx = w_lk_idx ^ ghr_q;
    assign w_up_ctr_idx = w_up_idx ^ ghr_q;

    // History shifts in the resolved direction on every update.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) ghr_d = (ghr_q << 1) | INDEX_BITS'(upd_taken);
    end

    // History register, cleared on reset.
    always_ff @(posedge Clk) begin
        if (!Reset_N) ghr_q <= '0;
        else          ghr_q <= ghr_d;
    end
`else
    assign w_lk_ctr_idx = w_lk_idx;
    assign w_up_ctr_idx = w_up_idx;
`endif

    // Lookup reads the registered table only, so a same-cycle update is
    // not visible until the next cycle.
    assign pred_hit   = entry_q[w_lk_idx].valid && (entry_q[w_lk_idx].tag == w_lk_tag);
    assign pred_taken = pred_hit && entry_q[w_lk_ctr_idx].ctr[CTR_BITS-1];
    assign Prediction = pred_taken ? entry_q[w_lk_idx].target : PC + WORD_SIZE'(1);

    assign w_up_hit = entry_q[w_up_idx].valid && (entry_q[w_up_idx].tag == w_up_tag);

    sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .i_ctr (entry_q[w_up_ctr_idx].ctr),
        .i_inc (upd_taken),
        .o_ctr (w_ctr_next)
    );

    // Train the hit entry, or allocate on a taken miss (direct-mapped).
    always_comb begin
        entry_d = entry_q;
        if (upd_valid) begin
            if (w_up_hit) begin
                entry_d[w_up_ctr_idx].ctr = w_ctr_next;
                if (upd_taken) entry_d[w_up_idx].target = upd_target;
            end else if (upd_taken) begin
                entry_d[w_up_idx].valid   = 1'b1;
                entry_d[w_up_idx].tag     = w_up_tag;
                entry_d[w_up_idx].target  = upd_target;
                entry_d[w_up_ctr_idx].ctr = c_WEAK_T;
            end
        end
    end

    // Saturating misprediction count, only for qualified updates.
    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (upd_valid && upd_mispredict && (mispredict_count_q != {WORD_SIZE{1'b1}}))
            mispredict_count_d = mispredict_count_q + WORD_SIZE'(1);
    end

    // Table and counter registers; reset wins over any update.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            for (int i = 0; i < ENTRIES; i++) entry_q[i] <= c_RESET_ENTRY;
            mispredict_count_q <= '0;
        end else begin
            entry_q            <= entry_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_predictor
// Description : Directed self-checking bench for btb_predictor (default
//               build, 16-bit PC, 16 entries, 2-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_predictor;

    logic        Clk;
    logic        Reset_N;
    logic [15:0] PC;
    logic [15:0] Prediction;
    logic        pred_hit;
    logic        pred_taken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic [15:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    btb_predictor dut (
        .Clk              (Clk),
        .Reset_N          (Reset_N),
        .PC               (PC),
        .Prediction       (Prediction),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .mispredict_count (mispredict_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One update cycle, then idle the update port.
    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt, input logic mp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    // Drive a fetch PC and check all lookup outputs.
    task automatic look(input string tag, input logic [15:0] pc, input logic [15:0] exp_pred,
                        input logic exp_hit, input logic exp_taken);
        PC = pc;
        #1;
        check({tag, "_pred"},  Prediction,          exp_pred);
        check({tag, "_hit"},   {15'd0, pred_hit},   {15'd0, exp_hit});
        check({tag, "_taken"}, {15'd0, pred_taken}, {15'd0, exp_taken});
    endtask

    initial begin
        Reset_N = 1'b0; PC = 16'h0000;
        upd_valid = 1'b0; upd_pc = 16'h0000; upd_taken = 1'b0;
        upd_target = 16'h0000; upd_mispredict = 1'b0;
        tick(); tick();
        Reset_N = 1'b1;

        // Reset state
        look("reset", 16'h0010, 16'h0011, 1'b0, 1'b0);
        check("reset_count", mispredict_count, 16'd0);

        // Same-cycle lookup during an allocating update sees old (miss) state
        PC = 16'h0010;
        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0040;
        #1;
        check("samecyc_pred", Prediction, 16'h0011);
        check("samecyc_hit", {15'd0, pred_hit}, 16'd0);
        tick();
        upd_valid = 1'b0;

        // Allocated weakly taken (ctr=10)
        look("alloc", 16'h0010, 16'h0040, 1'b1, 1'b1);

        // Saturate at 11, then one not-taken keeps predicting taken
        upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0);
        look("hyst1", 16'h0010, 16'h0040, 1'b1, 1'b1);
        // Second not-taken: 10 -> 01, predicts fall-through
        upd(16'h0010, 1'b0, 16'h0000, 1'b0);
        look("hyst2", 16'h0010, 16'h0011, 1'b1, 1'b0);

        // Saturate at 00: two more not-taken, then one taken gives 01 (still NT)
        upd(16'h0010, 1'b0, 16'h0000, 1'b0);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0);
        upd(16'h0010, 1'b1, 16'h0044, 1'b0);
        look("floor", 16'h0010, 16'h0011, 1'b1, 1'b0);
        // Taken hit again: 01 -> 10, new target 0048 replaces 0044
        upd(16'h0010, 1'b1, 16'h0048, 1'b0);
        look("retarget", 16'h0010, 16'h0048, 1'b1, 1'b1);

        // Tag conflict on index 0 evicts 0x0010
        upd(16'h0110, 1'b1, 16'h0080, 1'b0);
        look("conflict_old", 16'h0010, 16'h0011, 1'b0, 1'b0);
        look("conflict_new", 16'h0110, 16'h0080, 1'b1, 1'b1);

        // Not-taken miss allocates nothing
        upd(16'h0025, 1'b0, 16'h0099, 1'b0);
        look("nt_miss", 16'h0025, 16'h0026, 1'b0, 1'b0);

        // Fall-through wraps modulo 2^16
        look("wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b0);

        // Five qualified mispredictions
        for (int i = 0; i < 5; i++) upd(16'h0020, 1'b0, 16'h0000, 1'b1);
        check("mp_count5", mispredict_count, 16'd5);
        // Mispredict flag without upd_valid is ignored
        upd_mispredict = 1'b1;
        tick();
        upd_mispredict = 1'b0;
        check("mp_unqual", mispredict_count, 16'd5);

        // Reset beats a same-cycle allocating update
        Reset_N = 1'b0;
        upd(16'h0030, 1'b1, 16'h0050, 1'b1);
        Reset_N = 1'b1;
        check("rst_count", mispredict_count, 16'd0);
        look("rst_noalloc", 16'h0030, 16'h0031, 1'b0, 1'b0);
        look("rst_cleared", 16'h0110, 16'h0111, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
